// File: rtl/icache_down_req_arb.sv
// icache downstream miss-request arbiter: round-robin grant into a one-entry txreq register,
// in-flight entry-ID tracking against a credit limit, and rxdat return routing.
// Option ICACHE_ARB_PREF_PRIO_EN: prefetch channel (NUM_CH-1) lowest priority, one credit reserved for demand.
module icache_down_req_arb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PLD_W      = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned MAX_OUTSTD = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               ch_req_vld,
  output logic [NUM_CH-1:0]               ch_req_rdy,
  input  logic [NUM_CH*PLD_W-1:0]         ch_req_pld,
  input  logic [NUM_CH*ID_W-1:0]          ch_req_id,
  output logic                            txreq_vld,
  input  logic                            txreq_rdy,
  output logic [PLD_W-1:0]                txreq_pld,
  output logic [ID_W-1:0]                 txreq_entry_id,
  input  logic                            rxdat_vld,
  output logic                            rxdat_rdy,
  input  logic [DATA_W-1:0]               rxdat_data,
  input  logic [ID_W-1:0]                 rxdat_id,
  output logic [NUM_CH-1:0]               ch_dat_vld,
  output logic [DATA_W-1:0]               ch_dat_data,
  output logic [ID_W-1:0]                 ch_dat_id,
  output logic [$clog2(MAX_OUTSTD+1)-1:0] outstd_cnt,
  output logic                            err_unexp
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTD + 1);
  localparam int unsigned TBL_D = 2 ** ID_W;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             r_state;
  logic [CH_W-1:0]    r_ptr;
  logic [TBL_D-1:0]   r_valid;
  logic [CH_W-1:0]    r_chan [TBL_D];
  logic [PLD_W-1:0]   r_pld;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_dat_vld;
  logic [DATA_W-1:0]  r_dat_data;
  logic [ID_W-1:0]    r_dat_id;
  logic               r_err;

  logic               w_pend;
  logic               w_hs;
  logic               w_drain_ok;
  logic               w_credit_ok;
  logic               w_rx_hit;
  logic               w_gnt_any;
  logic [CH_W-1:0]    w_win;
  logic [CH_W-1:0]    w_idx;
  logic [CH_W-1:0]    w_ptr_nxt;
  logic [NUM_CH-1:0]  w_elig;
  logic [ID_W-1:0]    w_ch_id [NUM_CH];
  logic [PLD_W-1:0]   w_win_pld;
  logic [ID_W-1:0]    w_win_id;

  assign w_pend      = (r_state == S_FULL);
  assign w_hs        = w_pend && txreq_rdy;
  assign w_drain_ok  = !w_pend || txreq_rdy;
  // A request still held in the output register counts against the credit limit.
  assign w_credit_ok = (32'(r_cnt) + 32'(w_pend)) < MAX_OUTSTD;
  assign w_rx_hit    = rxdat_vld && r_valid[rxdat_id];
  assign w_ptr_nxt   = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);

`ifdef ICACHE_ARB_PREF_PRIO_EN
  logic w_pref_credit_ok;
  assign w_pref_credit_ok = (32'(r_cnt) + 32'(w_pend) + 32'd2) <= MAX_OUTSTD;
`endif

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch_id[i] = ch_req_id[i*ID_W +: ID_W];
      w_elig[i]  = ch_req_vld[i] && !r_valid[w_ch_id[i]] && w_credit_ok && w_drain_ok;
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    w_gnt_any = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_ptr) + k) % NUM_CH);
`ifdef ICACHE_ARB_PREF_PRIO_EN
      if (!w_gnt_any && w_elig[w_idx] && (32'(w_idx) != NUM_CH - 1)) begin
`else
      if (!w_gnt_any && w_elig[w_idx]) begin
`endif
        w_gnt_any = 1'b1;
        w_win     = w_idx;
      end
    end
`ifdef ICACHE_ARB_PREF_PRIO_EN
    if (!w_gnt_any && w_elig[NUM_CH-1] && w_pref_credit_ok) begin
      w_gnt_any = 1'b1;
      w_win     = CH_W'(NUM_CH - 1);
    end
`endif
  end

  always_comb begin
    w_win_pld = '0;
    w_win_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == CH_W'(i)) begin
        w_win_pld = ch_req_pld[i*PLD_W +: PLD_W];
        w_win_id  = w_ch_id[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_EMPTY;
      r_ptr      <= '0;
      r_valid    <= '0;
      for (int t = 0; t < TBL_D; t++) r_chan[t] <= '0;
      r_pld      <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_dat_vld  <= '0;
      r_dat_data <= '0;
      r_dat_id   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_gnt_any) r_state <= S_FULL;
        S_FULL:  if (w_hs && !w_gnt_any) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase

      if (w_gnt_any) begin
        r_pld            <= w_win_pld;
        r_id             <= w_win_id;
        r_ptr            <= w_ptr_nxt;
        r_valid[w_win_id] <= 1'b1;
        r_chan[w_win_id]  <= w_win;
      end

      // Grant needs valid clear and a hit needs valid set, so the two IDs never collide.
      if (w_rx_hit) r_valid[rxdat_id] <= 1'b0;

      case ({w_hs, w_rx_hit})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      r_dat_vld <= w_rx_hit ? (NUM_CH'(1) << r_chan[rxdat_id]) : '0;
      if (w_rx_hit) begin
        r_dat_data <= rxdat_data;
        r_dat_id   <= rxdat_id;
      end

      if (rxdat_vld && !r_valid[rxdat_id]) r_err <= 1'b1;
    end
  end

  assign ch_req_rdy     = (w_gnt_any && !rst_n) ? (NUM_CH'(1) << w_win) : '0;
  assign txreq_vld      = w_pend;
  assign txreq_pld      = r_pld;
  assign txreq_entry_id = r_id;
  assign rxdat_rdy      = 1'b1;
  assign ch_dat_vld     = r_dat_vld;
  assign ch_dat_data    = r_dat_data;
  assign ch_dat_id      = r_dat_id;
  assign outstd_cnt     = r_cnt;
  assign err_unexp      = r_err;

endmodule

// File: tb/tb_icache_down_req_arb.sv
// Directed bench for icache_down_req_arb: per-cycle vector table plus hand sequences
// for single request, mid-operation reset and the prefetch-priority option.
module tb_icache_down_req_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   ch_req_vld;
  logic [3:0]   ch_req_rdy;
  logic [255:0] ch_req_pld;
  logic [15:0]  ch_req_id;
  logic         txreq_vld;
  logic         txreq_rdy;
  logic [63:0]  txreq_pld;
  logic [3:0]   txreq_entry_id;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [255:0] rxdat_data;
  logic [3:0]   rxdat_id;
  logic [3:0]   ch_dat_vld;
  logic [255:0] ch_dat_data;
  logic [3:0]   ch_dat_id;
  logic [3:0]   outstd_cnt;
  logic         err_unexp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  icache_down_req_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy), .ch_req_pld(ch_req_pld), .ch_req_id(ch_req_id),
    .txreq_vld(txreq_vld), .txreq_rdy(txreq_rdy), .txreq_pld(txreq_pld), .txreq_entry_id(txreq_entry_id),
    .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy), .rxdat_data(rxdat_data), .rxdat_id(rxdat_id),
    .ch_dat_vld(ch_dat_vld), .ch_dat_data(ch_dat_data), .ch_dat_id(ch_dat_id),
    .outstd_cnt(outstd_cnt), .err_unexp(err_unexp)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] ids;
    logic        trdy;
    logic        rxv;
    logic [3:0]  rxid;
    logic [3:0]  e_rdy;
    logic        e_txv;
    logic [3:0]  e_txid;
    int          e_txch;
    logic [3:0]  e_cnt;
    logic [3:0]  e_datv;
    logic [3:0]  e_datid;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic [3:0] vld, logic [15:0] ids, logic trdy, logic rxv, logic [3:0] rxid,
                              logic [3:0] e_rdy, logic e_txv, logic [3:0] e_txid, int e_txch,
                              logic [3:0] e_cnt, logic [3:0] e_datv, logic [3:0] e_datid, logic e_err);
    vec_t v;
    v.vld = vld; v.ids = ids; v.trdy = trdy; v.rxv = rxv; v.rxid = rxid;
    v.e_rdy = e_rdy; v.e_txv = e_txv; v.e_txid = e_txid; v.e_txch = e_txch;
    v.e_cnt = e_cnt; v.e_datv = e_datv; v.e_datid = e_datid; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [63:0] pld_of(int ch, logic [3:0] id);
    return {40'h0, 8'hC0 + 8'(ch), 12'h0, id};
  endfunction

  function automatic logic [255:0] dat_of(logic [3:0] id);
    return {8{28'hDA7A000, id}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [15:0] ids, input logic trdy,
                       input logic rxv, input logic [3:0] rxid);
    ch_req_vld = vld;
    ch_req_id  = ids;
    for (int i = 0; i < 4; i++) ch_req_pld[i*64 +: 64] = pld_of(i, ids[i*4 +: 4]);
    txreq_rdy  = trdy;
    rxdat_vld  = rxv;
    rxdat_id   = rxid;
    rxdat_data = dat_of(rxid);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
  endtask

  vec_t tbl[27];

  initial begin
    tbl[0]  = mk(4'hF, 16'h3210, 1, 0, 4'h0,  4'h1, 1, 4'h0, 0, 4'd0, 4'h0, 4'h0, 0);
    tbl[1]  = mk(4'hF, 16'h7654, 1, 0, 4'h0,  4'h2, 1, 4'h5, 1, 4'd1, 4'h0, 4'h0, 0);
    tbl[2]  = mk(4'hF, 16'hBA98, 1, 0, 4'h0,  4'h4, 1, 4'hA, 2, 4'd2, 4'h0, 4'h0, 0);
    tbl[3]  = mk(4'hF, 16'hFEDC, 1, 0, 4'h0,  4'h8, 1, 4'hF, 3, 4'd3, 4'h0, 4'h0, 0);
    tbl[4]  = mk(4'hF, 16'h4321, 1, 0, 4'h0,  4'h1, 1, 4'h1, 0, 4'd4, 4'h0, 4'h0, 0);
    for (int r = 5; r < 10; r++)
      tbl[r] = mk(4'hF, 16'h9876, 0, 0, 4'h0, 4'h0, 1, 4'h1, 0, 4'd4, 4'h0, 4'h0, 0);
    tbl[10] = mk(4'hF, 16'h9876, 1, 0, 4'h0,  4'h2, 1, 4'h7, 1, 4'd5, 4'h0, 4'h0, 0);
    tbl[11] = mk(4'hF, 16'hBA98, 1, 0, 4'h0,  4'h8, 1, 4'hB, 3, 4'd6, 4'h0, 4'h0, 0);
    tbl[12] = mk(4'hF, 16'h4332, 1, 0, 4'h0,  4'h1, 1, 4'h2, 0, 4'd7, 4'h0, 4'h0, 0);
    tbl[13] = mk(4'hF, 16'h6543, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd8, 4'h0, 4'h0, 0);
    tbl[14] = mk(4'hF, 16'h6543, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd8, 4'h0, 4'h0, 0);
    tbl[15] = mk(4'h0, 16'h0000, 1, 1, 4'h2,  4'h0, 0, 4'h0, 0, 4'd7, 4'h1, 4'h2, 0);
    tbl[16] = mk(4'hF, 16'hCD3E, 1, 0, 4'h0,  4'h2, 1, 4'h3, 1, 4'd7, 4'h0, 4'h0, 0);
    tbl[17] = mk(4'h0, 16'h0000, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd8, 4'h0, 4'h0, 0);
    tbl[18] = mk(4'h0, 16'h0000, 1, 1, 4'h5,  4'h0, 0, 4'h0, 0, 4'd7, 4'h2, 4'h5, 0);
    tbl[19] = mk(4'h1, 16'h0000, 1, 1, 4'h0,  4'h0, 0, 4'h0, 0, 4'd6, 4'h1, 4'h0, 0);
    tbl[20] = mk(4'h1, 16'h0000, 1, 0, 4'h0,  4'h1, 1, 4'h0, 0, 4'd6, 4'h0, 4'h0, 0);
    tbl[21] = mk(4'h0, 16'h0000, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd7, 4'h0, 4'h0, 0);
    tbl[22] = mk(4'h0, 16'h0000, 1, 1, 4'h9,  4'h0, 0, 4'h0, 0, 4'd7, 4'h0, 4'h0, 1);
    tbl[23] = mk(4'h0, 16'h0000, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd7, 4'h0, 4'h0, 1);
    tbl[24] = mk(4'h0, 16'h0000, 1, 1, 4'hA,  4'h0, 0, 4'h0, 0, 4'd6, 4'h4, 4'hA, 1);
    tbl[25] = mk(4'h6, 16'h0440, 1, 0, 4'h0,  4'h2, 1, 4'h4, 1, 4'd6, 4'h0, 4'h0, 1);
    tbl[26] = mk(4'h4, 16'h0440, 1, 0, 4'h0,  4'h0, 0, 4'h0, 0, 4'd7, 4'h0, 4'h0, 1);

    // Reset values and a single request with its return.
    do_reset();
    chk("reset txreq_vld", 256'(txreq_vld), 256'(0));
    chk("reset outstd_cnt", 256'(outstd_cnt), 256'(0));
    chk("reset ch_dat_vld", 256'(ch_dat_vld), 256'(0));
    chk("reset err_unexp", 256'(err_unexp), 256'(0));
    chk("reset rxdat_rdy", 256'(rxdat_rdy), 256'(1));
    chk("reset ch_req_rdy", 256'(ch_req_rdy), 256'(0));

    drive(4'b0010, 16'h0030, 1'b1, 1'b0, 4'h0);
    ch_req_pld[64 +: 64] = 64'hABCD;
    #1 chk("single ch_req_rdy", 256'(ch_req_rdy), 256'(4'b0010));
    step();
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    chk("single txreq_vld", 256'(txreq_vld), 256'(1));
    chk("single entry_id", 256'(txreq_entry_id), 256'(3));
    chk("single pld", 256'(txreq_pld), 256'(64'hABCD));
    chk("single cnt before hs", 256'(outstd_cnt), 256'(0));
    step();
    chk("single txreq_vld drop", 256'(txreq_vld), 256'(0));
    chk("single cnt after hs", 256'(outstd_cnt), 256'(1));
    drive(4'h0, 16'h0, 1'b1, 1'b1, 4'h3);
    step();
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    chk("single ch_dat_vld", 256'(ch_dat_vld), 256'(4'b0010));
    chk("single ch_dat_id", 256'(ch_dat_id), 256'(3));
    chk("single ch_dat_data", ch_dat_data, dat_of(4'h3));
    chk("single cnt after ret", 256'(outstd_cnt), 256'(0));
    step();
    chk("single ch_dat_vld pulse", 256'(ch_dat_vld), 256'(0));

`ifndef ICACHE_ARB_PREF_PRIO_EN
    // Round robin, backpressure, ID blocking, credit limit, unexpected return.
    do_reset();
    for (int r = 0; r < 27; r++) begin
      drive(tbl[r].vld, tbl[r].ids, tbl[r].trdy, tbl[r].rxv, tbl[r].rxid);
      #1 chk($sformatf("row%0d ch_req_rdy", r), 256'(ch_req_rdy), 256'(tbl[r].e_rdy));
      step();
      chk($sformatf("row%0d txreq_vld", r), 256'(txreq_vld), 256'(tbl[r].e_txv));
      if (tbl[r].e_txv) begin
        chk($sformatf("row%0d entry_id", r), 256'(txreq_entry_id), 256'(tbl[r].e_txid));
        chk($sformatf("row%0d pld", r), 256'(txreq_pld), 256'(pld_of(tbl[r].e_txch, tbl[r].e_txid)));
      end
      chk($sformatf("row%0d outstd_cnt", r), 256'(outstd_cnt), 256'(tbl[r].e_cnt));
      chk($sformatf("row%0d ch_dat_vld", r), 256'(ch_dat_vld), 256'(tbl[r].e_datv));
      if (tbl[r].e_datv != 4'h0) begin
        chk($sformatf("row%0d ch_dat_id", r), 256'(ch_dat_id), 256'(tbl[r].e_datid));
        chk($sformatf("row%0d ch_dat_data", r), ch_dat_data, dat_of(tbl[r].e_datid));
      end
      chk($sformatf("row%0d err_unexp", r), 256'(err_unexp), 256'(tbl[r].e_err));
    end
`else
    // Prefetch channel yields to demand and keeps one credit in reserve.
    do_reset();
    for (int j = 0; j < 7; j++) begin
      drive(4'b0001, 16'(j), 1'b1, 1'b0, 4'h0);
      step();
    end
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    step();
    chk("pref cnt7", 256'(outstd_cnt), 256'(7));
    drive(4'b1001, 16'h9008, 1'b1, 1'b0, 4'h0);
    #1 chk("pref demand wins", 256'(ch_req_rdy), 256'(4'b0001));
    step();
    drive(4'b1000, 16'h9008, 1'b1, 1'b0, 4'h0);
    #1 chk("pref no credit", 256'(ch_req_rdy), 256'(4'b0000));
    step();
    chk("pref cnt8", 256'(outstd_cnt), 256'(8));
    drive(4'b1000, 16'h9008, 1'b1, 1'b1, 4'h0);
    step();
    drive(4'b1000, 16'h9008, 1'b1, 1'b0, 4'h0);
    #1 chk("pref reserve at 7", 256'(ch_req_rdy), 256'(4'b0000));
    drive(4'b1000, 16'h9008, 1'b1, 1'b1, 4'h1);
    step();
    drive(4'b1000, 16'h9008, 1'b1, 1'b0, 4'h0);
    #1 chk("pref granted at 6", 256'(ch_req_rdy), 256'(4'b1000));
    step();
    chk("pref txreq id", 256'(txreq_entry_id), 256'(9));
`endif

    // Asynchronous reset while a request is in the output register.
    do_reset();
    drive(4'b0010, 16'h0030, 1'b1, 1'b0, 4'h0);
    step();
    drive(4'b0100, 16'h0400, 1'b1, 1'b0, 4'h0);
    step();
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    chk("midrst txreq_vld before", 256'(txreq_vld), 256'(1));
    chk("midrst entry_id before", 256'(txreq_entry_id), 256'(4));
    chk("midrst cnt before", 256'(outstd_cnt), 256'(1));
    #2 rst_n = 1'b1;
    #1 chk("midrst txreq_vld async", 256'(txreq_vld), 256'(0));
    chk("midrst cnt async", 256'(outstd_cnt), 256'(0));
    #1 rst_n = 1'b0;
    drive(4'h0, 16'h0, 1'b1, 1'b1, 4'h3);
    step();
    drive(4'h0, 16'h0, 1'b1, 1'b0, 4'h0);
    chk("midrst err_unexp", 256'(err_unexp), 256'(1));
    chk("midrst ch_dat_vld", 256'(ch_dat_vld), 256'(0));
    chk("midrst cnt", 256'(outstd_cnt), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_down_req_arb.md
Name: icache_down_req_arb

Overview:
- Parametrised N-channel downstream miss-request arbiter and return router for the icache.
- Sits between the MSHR entries and the prefetcher (request channels) and the downstream txreq/rxdat port.
- Round-robin arbitrates requests, tracks in-flight entry IDs against an outstanding-credit limit, and routes returning rxdat beats back to the originating channel.

Parameters:
- NUM_CH, 4, number of request channels (>=2); channel NUM_CH-1 is the prefetch channel.
- PLD_W, 64, request payload width (packed pc_req_t).
- ID_W, 4, entry ID width; tracking table depth is 2**ID_W.
- DATA_W, 256, rxdat payload width.
- MAX_OUTSTD, 8, maximum in-flight requests (1..2**ID_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1).
- ch_req_vld  in  NUM_CH  per-channel request valid.
- ch_req_rdy  out  NUM_CH  per-channel request ready.
- ch_req_pld  in  NUM_CH*PLD_W  per-channel payload; channel i at bits [i*PLD_W +: PLD_W].
- ch_req_id  in  NUM_CH*ID_W  per-channel entry ID.
- txreq_vld  out  1  downstream request valid.
- txreq_rdy  in  1  downstream request ready.
- txreq_pld  out  PLD_W  downstream payload.
- txreq_entry_id  out  ID_W  downstream entry ID.
- rxdat_vld  in  1  return data valid.
- rxdat_rdy  out  1  return data ready; tied to 1.
- rxdat_data  in  DATA_W  return data.
- rxdat_id  in  ID_W  return entry ID.
- ch_dat_vld  out  NUM_CH  one-hot routed return valid.
- ch_dat_data  out  DATA_W  routed data, shared by all channels.
- ch_dat_id  out  ID_W  routed entry ID.
- outstd_cnt  out  $clog2(MAX_OUTSTD+1)  current in-flight count.
- err_unexp  out  1  sticky: rxdat arrived for an ID that is not in flight.

Behaviour:
- Reset values: all outputs 0 except rxdat_rdy = 1; RR pointer = 0; all table valid bits = 0.
- Eligibility: channel i is eligible when vld_i is high, its ID is not valid in the table, outstd_cnt + pending < MAX_OUTSTD, and the output register is EMPTY or draining this cycle.
- Output register FSM:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on txreq_vld && txreq_rdy with no new grant.
  - FULL -> FULL on handshake with a new grant in the same cycle (back-to-back, 1 req/cycle).
  - txreq_vld = (state == FULL).
  - pld and ID stay stable while vld && !rdy.
- Arbitration and handshake:
  - Round-robin starts at the pointer; the pointer moves to winner+1 mod NUM_CH on grant.
  - ch_req_rdy is one-hot, asserted only for the winner; a grant is ch_req_vld && ch_req_rdy.
  - Latency: channel grant to txreq_vld is 1 cycle.
- Table write on grant: valid[id] = 1, chan[id] = winner.
- Credits:
  - outstd_cnt increments on a txreq handshake and decrements on an accepted rxdat for a valid ID.
  - Both in the same cycle leaves it unchanged.
  - A request sitting in the output register counts as pending against the limit.
- Return path:
  - On rxdat_vld with valid[rxdat_id] set, the next cycle drives ch_dat_vld[chan[rxdat_id]] = 1 with data and ID registered; valid[rxdat_id] is cleared.
  - If valid[rxdat_id] is clear: the beat is dropped, err_unexp is set (cleared only by reset), and outstd_cnt is unchanged.
- Simultaneous events:
  - rxdat releases ID X while a channel requests X: the request is blocked this cycle (registered valid) and eligible next cycle.
  - Two channels present the same ID: only the RR winner is granted; the other is blocked by valid the next cycle.
- At outstd_cnt == MAX_OUTSTD: all ch_req_rdy = 0; txreq drains normally.
- Reset mid-operation: all state is cleared asynchronously; an in-flight txreq_vld drops immediately; returns after reset flag err_unexp.

Optional Feature:
- Macro: ICACHE_ARB_PREF_PRIO_EN.
- Defined:
  - Channel NUM_CH-1 (prefetch) is excluded from RR and granted only when no other channel is eligible.
  - It is granted only when outstd_cnt + pending <= MAX_OUTSTD-2, reserving one credit for demand.
- Undefined: all NUM_CH channels share plain RR with no reservation.

Test Plan:
- Single request: ch1 requests ID 3 with pld 0xABCD and txreq_rdy = 1 -> txreq_vld the next cycle with entry_id 3 and pld 0xABCD; outstd_cnt goes 0 -> 1.
- Round robin: all 4 channels request continuously with rdy = 1 -> grant order 0,1,2,3,0; one txreq per cycle.
- Backpressure: txreq_rdy = 0 for 5 cycles -> txreq pld/ID stay stable and all ch_req_rdy = 0; rdy = 1 -> handshake and the next grant in the same cycle.
- Credit limit (MAX_OUTSTD = 8): issue 8 with no returns -> ch_req_rdy = 0; one rxdat ID 2 -> ch_dat_vld[owner of ID 2] one cycle later, outstd_cnt = 7, next grant issued.
- Unexpected return: rxdat_id 9 never issued -> no ch_dat_vld, err_unexp = 1 held, outstd_cnt unchanged.
- With ICACHE_ARB_PREF_PRIO_EN, ch3 and ch0 request and outstd_cnt = 7 -> ch0 granted, ch3 held until outstd_cnt <= 6.
